fir_out_sd_dac: RTL and testbench

Output stage placed directly downstream of `fir_n`. It captures the filter's signed `y_out` once per sample period, marked by the rising edge of the divided sample clock `clk_d` from `clk_divider`. The captured sample is scaled by an arithmetic right shift, saturated and converted to offset binary. A first-order delta-sigma modulator running at the full `clk` rate turns it into a 1-bit density stream that drives an external RC-filtered pin. Clipping is reported through a sticky flag and a saturating counter.

---
 rtl/fir_out_sd_dac.sv | 169 ++++++++++++++++
 tb/tb_fir_out_sd_dac.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_out_sd_dac.sv
// fir_out_sd_dac
// Output stage behind fir_n. The filter output is captured once per sample
// period, on the rising edge of the divided clock clk_d. The captured sample
// is scaled by an arithmetic right shift, saturated and turned into an
// offset-binary code. A first-order delta-sigma modulator running at the full
// clk rate turns that code into a 1-bit density stream for an RC-filtered pin.
// Saturated captures are reported by a sticky flag and a saturating counter.
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-high reset
//   clk_d         divided sample clock, sampled as data on clk
//   ena           enable; low freezes everything except the clk_d edge detector
//   y_in          signed N-bit sample from fir_n
//   clip_clr      synchronous clear of clip / clip_count
//   dac_out       delta-sigma bitstream (registered)
//   sample_strobe one-cycle pulse when a new code is loaded
//   code          current offset-binary code
//   clip          sticky flag: a captured sample saturated
//   clip_count    number of saturated captures, holds at 16'hFFFF
module fir_out_sd_dac #(
    parameter int N        = 32,
    parameter int SHIFT    = 8,
    parameter int OUT_BITS = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clk_d,
    input  logic                ena,
    input  logic [N-1:0]        y_in,
    input  logic                clip_clr,
    output logic                dac_out,
    output logic                sample_strobe,
    output logic [OUT_BITS-1:0] code,
    output logic                clip,
    output logic [15:0]         clip_count
);

    // Saturation bounds expressed at the full input width so the comparison
    // happens before any bits are dropped.
    localparam logic signed [N-1:0] SAT_MAX = {{(N-OUT_BITS+1){1'b0}}, {(OUT_BITS-1){1'b1}}};
    localparam logic signed [N-1:0] SAT_MIN = {{(N-OUT_BITS+1){1'b1}}, {(OUT_BITS-1){1'b0}}};
    localparam logic [OUT_BITS-1:0] MID_CODE = {1'b1, {(OUT_BITS-1){1'b0}}};
    localparam logic [OUT_BITS-1:0] SAT_MAX_CODE = {1'b0, {(OUT_BITS-1){1'b1}}};
    localparam logic [OUT_BITS-1:0] SAT_MIN_CODE = {1'b1, {(OUT_BITS-1){1'b0}}};
    localparam logic [15:0] COUNT_MAX = 16'hFFFF;

    logic                       clk_d_q_r;
    logic                       rise_s;
    logic                       capture_s;
    logic signed [N-1:0]        shifted_s;
    logic                       sat_hi_s;
    logic                       sat_lo_s;
    logic                       clip_hit_s;
    logic [OUT_BITS-1:0]        sat_s;
    logic [OUT_BITS-1:0]        next_code_s;
    logic [OUT_BITS:0]          acc_sum_s;
    logic [OUT_BITS-1:0]        acc_r;
    logic [OUT_BITS-1:0]        code_r;
    logic                       dac_out_r;
    logic                       strobe_r;
    logic                       clip_r;
    logic [15:0]                clip_count_r;

    // Rise detection on the sampled divided clock, plus capture qualification.
    always_comb begin
        rise_s    = clk_d & ~clk_d_q_r;
        capture_s = rise_s & ena;
    end

    // Scale, saturate and convert the incoming sample to offset binary.
    always_comb begin
        shifted_s  = $signed(y_in) >>> SHIFT;
        sat_hi_s   = (shifted_s > SAT_MAX);
        sat_lo_s   = (shifted_s < SAT_MIN);
        clip_hit_s = sat_hi_s | sat_lo_s;
        if (sat_hi_s) begin
            sat_s = SAT_MAX_CODE;
        end else if (sat_lo_s) begin
            sat_s = SAT_MIN_CODE;
        end else begin
            sat_s = shifted_s[OUT_BITS-1:0];
        end
        // Adding half scale to an in-range two's complement value is the same
        // as inverting its sign bit.
        next_code_s = {~sat_s[OUT_BITS-1], sat_s[OUT_BITS-2:0]};
    end

    // Modulator adder: the carry out of the phase accumulator is the output bit.
    always_comb begin
        acc_sum_s = {1'b0, acc_r} + {1'b0, code_r};
    end

    // clk_d edge detector; keeps tracking even while disabled so that a
    // re-enable with clk_d already high is not mistaken for a rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_d_q_r <= 1'b0;
        end else begin
            clk_d_q_r <= clk_d;
        end
    end

    // Code register and the one-cycle load strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_r   <= MID_CODE;
            strobe_r <= 1'b0;
        end else begin
            strobe_r <= capture_s;
            if (capture_s) begin
                code_r <= next_code_s;
            end else begin
                code_r <= code_r;
            end
        end
    end

    // First-order delta-sigma: acc together with dac_out forms the
    // OUT_BITS+1 bit accumulator {carry, phase}.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r     <= {OUT_BITS{1'b0}};
            dac_out_r <= 1'b0;
        end else if (ena) begin
            acc_r     <= acc_sum_s[OUT_BITS-1:0];
            dac_out_r <= acc_sum_s[OUT_BITS];
        end else begin
            acc_r     <= acc_r;
            dac_out_r <= dac_out_r;
        end
    end

    // Clip reporting; a saturating capture takes priority over a clear, so a
    // coincident clear restarts the count at one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clip_r       <= 1'b0;
            clip_count_r <= 16'h0000;
        end else if (ena) begin
            if (capture_s && clip_hit_s) begin
                clip_r <= 1'b1;
                if (clip_clr) begin
                    clip_count_r <= 16'h0001;
                end else if (clip_count_r == COUNT_MAX) begin
                    clip_count_r <= COUNT_MAX;
                end else begin
                    clip_count_r <= clip_count_r + 16'h0001;
                end
            end else if (clip_clr) begin
                clip_r       <= 1'b0;
                clip_count_r <= 16'h0000;
            end else begin
                clip_r       <= clip_r;
                clip_count_r <= clip_count_r;
            end
        end else begin
            clip_r       <= clip_r;
            clip_count_r <= clip_count_r;
        end
    end

    assign dac_out       = dac_out_r;
    assign sample_strobe = strobe_r;
    assign code          = code_r;
    assign clip          = clip_r;
    assign clip_count    = clip_count_r;

endmodule

// File: tb/tb_fir_out_sd_dac.sv
// Testbench for fir_out_sd_dac (N=32, SHIFT=8, OUT_BITS=12).
// Table-driven captures, random captures against an arithmetic reference,
// density windows and hand-written enable / clear / reset sequences.
module tb_fir_out_sd_dac;

    logic        clk;
    logic        run_clk;
    logic        rst;
    logic        clk_d;
    logic        ena;
    logic [31:0] y_in;
    logic        clip_clr;
    logic        dac_out;
    logic        sample_strobe;
    logic [11:0] code;
    logic        clip;
    logic [15:0] clip_count;

    int n_checks;
    int n_fail;

    // reference state
    int m_code;
    int m_clip;
    int m_count;

    typedef struct {
        int          y;
        logic [11:0] exp_code;
        logic        exp_sat;
        int          post;    // 0 none, 1 density window, 2 dac stays low
    } vec_t;

    vec_t vecs [12];

    fir_out_sd_dac #(.N(32), .SHIFT(8), .OUT_BITS(12)) dut (
        .clk           (clk),
        .rst           (rst),
        .clk_d         (clk_d),
        .ena           (ena),
        .y_in          (y_in),
        .clip_clr      (clip_clr),
        .dac_out       (dac_out),
        .sample_strobe (sample_strobe),
        .code          (code),
        .clip          (clip),
        .clip_count    (clip_count)
    );

    always #5 if (run_clk) clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // floor(y / 256), then clamp to 12-bit signed, then offset by 2048
    function automatic int ref_scaled(input int y);
        int s;
        if (y >= 0) s = y / 256;
        else        s = -((-y + 255) / 256);
        return s;
    endfunction

    function automatic int ref_code(input int y);
        int s;
        s = ref_scaled(y);
        if (s > 2047)  s = 2047;
        if (s < -2048) s = -2048;
        return s + 2048;
    endfunction

    function automatic bit ref_sat(input int y);
        int s;
        s = ref_scaled(y);
        return (s > 2047) || (s < -2048);
    endfunction

    task automatic model_capture(input int y, input bit clr);
        m_code = ref_code(y);
        if (ref_sat(y)) begin
            m_clip  = 1;
            m_count = clr ? 1 : ((m_count == 65535) ? 65535 : m_count + 1);
        end else if (clr) begin
            m_clip  = 0;
            m_count = 0;
        end
    endtask

    // Called just after a negedge: present a rise and stop 1 ns after the
    // sampling edge.
    task automatic capture(input int y, input logic clr);
        y_in     = y;
        clk_d    = 1'b1;
        clip_clr = clr;
        @(posedge clk);
        #1;
        clip_clr = 1'b0;
    endtask

    // Drop clk_d and leave the bench just after a negedge.
    task automatic settle();
        @(negedge clk);
        clk_d = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_state(input string tag);
        check({tag, ".code"}, 32'(code), 32'(m_code));
        check({tag, ".clip"}, 32'(clip), 32'(m_clip));
        check({tag, ".clip_count"}, 32'(clip_count), 32'(m_count));
    endtask

    task automatic density_window(input string tag, input int exp_ones);
        int ones;
        ones = 0;
        repeat (3) @(negedge clk);
        repeat (4096) begin
            @(negedge clk);
            ones += int'(dac_out);
        end
        check(tag, 32'(ones), 32'(exp_ones));
    endtask

    initial begin
        logic saved_dac;
        logic saved_strobe_seen;
        n_checks = 0;
        n_fail   = 0;
        clk      = 1'b0;
        run_clk  = 1'b0;
        clk_d    = 1'b0;
        ena      = 1'b0;
        y_in     = 32'd0;
        clip_clr = 1'b0;
        rst      = 1'b0;

        vecs[0]  = '{0,        12'd2048, 1'b0, 1};
        vecs[1]  = '{193000,   12'd2801, 1'b0, 1};
        vecs[2]  = '{376000,   12'd3516, 1'b0, 0};
        vecs[3]  = '{-1,       12'd2047, 1'b0, 0};
        vecs[4]  = '{-256,     12'd2047, 1'b0, 0};
        vecs[5]  = '{-257,     12'd2046, 1'b0, 0};
        vecs[6]  = '{1000000,  12'd4095, 1'b1, 0};
        vecs[7]  = '{-1000000, 12'd0,    1'b1, 2};
        vecs[8]  = '{524287,   12'd4095, 1'b0, 0};
        vecs[9]  = '{524288,   12'd4095, 1'b1, 0};
        vecs[10] = '{-524288,  12'd0,    1'b0, 0};
        vecs[11] = '{-524289,  12'd0,    1'b1, 0};

        // Reset with the clock stopped: values must appear immediately.
        #3;
        rst = 1'b1;
        #1;
        check("rst.code", 32'(code), 32'd2048);
        check("rst.dac_out", 32'(dac_out), 32'd0);
        check("rst.strobe", 32'(sample_strobe), 32'd0);
        check("rst.clip", 32'(clip), 32'd0);
        check("rst.clip_count", 32'(clip_count), 32'd0);
        m_code = 2048; m_clip = 0; m_count = 0;

        run_clk = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ena = 1'b1;
        @(negedge clk);

        // Table of captures
        for (int i = 0; i < 12; i++) begin
            capture(vecs[i].y, 1'b0);
            check($sformatf("vec%0d.code", i), 32'(code), 32'(vecs[i].exp_code));
            check($sformatf("vec%0d.strobe", i), 32'(sample_strobe), 32'd1);
            m_clip  = m_clip | int'(vecs[i].exp_sat);
            m_count = m_count + int'(vecs[i].exp_sat);
            m_code  = int'(vecs[i].exp_code);
            check($sformatf("vec%0d.clip", i), 32'(clip), 32'(m_clip));
            check($sformatf("vec%0d.clip_count", i), 32'(clip_count), 32'(m_count));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d.strobe_off", i), 32'(sample_strobe), 32'd0);
            if (vecs[i].post == 2) begin
                for (int k = 0; k < 20; k++) begin
                    @(posedge clk);
                    #1;
                    check($sformatf("vec%0d.dac_low", i), 32'(dac_out), 32'd0);
                end
            end
            settle();
            if (vecs[i].post == 1) begin
                density_window($sformatf("vec%0d.window", i), int'(vecs[i].exp_code));
            end
        end

        // Full-scale density
        capture(1000000, 1'b0);
        model_capture(1000000, 1'b0);
        check_state("fs");
        settle();
        density_window("fs.window", 4095);

        // Clear with no clip in that cycle
        clip_clr = 1'b1;
        @(negedge clk);
        clip_clr = 1'b0;
        m_clip = 0; m_count = 0;
        check_state("clr");

        // Clear coincident with a saturating capture
        capture(1000000, 1'b0);
        model_capture(1000000, 1'b0);
        settle();
        capture(-1000000, 1'b1);
        model_capture(-1000000, 1'b1);
        check_state("clr_sat");
        settle();

        // Counter saturation at FFFF
        force dut.clip_count_r = 16'hFFFF;
        @(negedge clk);
        release dut.clip_count_r;
        m_count = 65535;
        capture(1000000, 1'b0);
        model_capture(1000000, 1'b0);
        check_state("count_hold");
        settle();

        // Random captures
        clip_clr = 1'b0;
        for (int i = 0; i < 40; i++) begin
            int y;
            y = int'($urandom_range(1300000, 0)) - 650000;
            capture(y, 1'b0);
            model_capture(y, 1'b0);
            check_state($sformatf("rnd%0d", i));
            settle();
        end

        // Enable gating: a rise while disabled is dropped and dac is frozen.
        ena = 1'b0;
        saved_dac = dac_out;
        capture(193000, 1'b0);
        check("gate.strobe", 32'(sample_strobe), 32'd0);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            check("gate.dac_frozen", 32'(dac_out), 32'(saved_dac));
        end
        check("gate.code", 32'(code), 32'(m_code));
        // Re-enable with clk_d still high: no capture.
        @(negedge clk);
        ena = 1'b1;
        saved_strobe_seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            saved_strobe_seen = saved_strobe_seen | sample_strobe;
        end
        check("reena.strobe", 32'(saved_strobe_seen), 32'd0);
        check("reena.code", 32'(code), 32'(m_code));
        settle();
        capture(193000, 1'b0);
        model_capture(193000, 1'b0);
        check_state("reena.next");
        settle();

        // Async reset with a rise in flight
        y_in  = 32'(1000000);
        clk_d = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("arst.code", 32'(code), 32'd2048);
        check("arst.dac_out", 32'(dac_out), 32'd0);
        check("arst.strobe", 32'(sample_strobe), 32'd0);
        check("arst.clip", 32'(clip), 32'd0);
        clk_d = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        saved_strobe_seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            saved_strobe_seen = saved_strobe_seen | sample_strobe;
        end
        check("arst.no_strobe", 32'(saved_strobe_seen), 32'd0);
        check("arst.code_after", 32'(code), 32'd2048);
        check("arst.count_after", 32'(clip_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
